sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of all write and read data paths.
REQ-002 Parameter RAM_DEPTH, default 64, SHALL set the number of RAM words; localparam ADDR_WIDTH = $clog2(RAM_DEPTH).
REQ-003 Parameter NUM_REQ, default 4, SHALL set the requester count (legal range 2..16); localparam ID_WIDTH = $clog2(NUM_REQ).
REQ-004 The design SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- I_Clk  in  1  clock, all logic on rising edge
- I_Reset  in  1  synchronous active-high reset
- I_WrReq  in  NUM_REQ  per-requester write request
- I_WrAddr  in  NUM_REQ*ADDR_WIDTH  write addresses, requester i at slice i
- I_WrData  in  NUM_REQ*DATA_WIDTH  write data, requester i at slice i
- O_WrGnt  out  NUM_REQ  one-hot write grant
- I_RdReq  in  NUM_REQ  per-requester read request
- I_RdAddr  in  NUM_REQ*ADDR_WIDTH  read addresses
- O_RdGnt  out  NUM_REQ  one-hot read grant
- O_RdValid  out  1  read data valid
- O_RdId  out  ID_WIDTH  requester index owning O_RdData
- O_RdData  out  DATA_WIDTH  returned read data
- O_RamWrEn / O_RamWrAddr / O_RamWrData  out  1 / ADDR_WIDTH / DATA_WIDTH  RAM write port
- O_RamRdEn / O_RamRdAddr  out  1 / ADDR_WIDTH  RAM read port
- I_RamRdData  in  DATA_WIDTH  RAM read data, registered, valid 1 cycle after O_RamRdEn

Function
REQ-006 Write and read ports SHALL be arbitrated independently, each with its own round-robin pointer (WrPtr, RdPtr, ID_WIDTH bits).
REQ-007 Grant SHALL go to the first requesting index at or after the pointer, scanning upward with wrap from NUM_REQ-1 to 0.
REQ-008 Grants SHALL be combinational from the current requests and pointer, at most one bit set per port, and all-zero when no request is active.
REQ-009 A request SHALL be held with stable address/data until granted; a grant SHALL complete the transfer in that cycle (no multi-cycle ownership).
REQ-010 On a write grant to i: O_RamWrEn=1, and O_RamWrAddr/O_RamWrData SHALL equal requester i's slice in the same cycle; WrPtr SHALL become (i+1) mod NUM_REQ on the next edge.
REQ-011 On a read grant to i: O_RamRdEn=1 and O_RamRdAddr=slice i in the same cycle; RdPtr SHALL become (i+1) mod NUM_REQ; O_RdValid=1 and O_RdId=i on the next cycle.
REQ-012 O_RdData SHALL pass I_RamRdData through combinationally; it is defined only while O_RdValid=1.
REQ-013 With no grant, pointers SHALL hold, RAM enables SHALL be 0, and RAM address/data outputs SHALL be 0.
REQ-014 Read latency from grant to O_RdValid SHALL be exactly 1 cycle, with back-to-back reads at one per cycle.
REQ-015 A same-cycle read and write to the same address SHALL both be granted with no forwarding; the read SHALL return the pre-write contents.
REQ-016 Multiple reads in flight SHALL not occur, since latency is 1; no return queue is required.

Reset
REQ-017 While I_Reset=1 at a clock edge: WrPtr=0, RdPtr=0, O_RdValid=0, O_RdId=0.
REQ-018 While I_Reset=1, all grants and RAM enables SHALL be forced to 0 regardless of requests.
REQ-019 A read granted in the cycle before reset assertion SHALL not produce O_RdValid after the reset edge.
REQ-020 The first arbitration after reset release SHALL favour requester 0.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with NUM_REQ=4, DATA_WIDTH=32, RAM_DEPTH=64:
- Reset, then I_WrReq=4'b1111 held 4 cycles -> O_WrGnt = 0001, 0010, 0100, 1000; RAM written with each slice's addr/data.
- Write 0xDEADBEEF to addr 5 via req 2; next cycle read addr 5 via req 3 -> one cycle later O_RdValid=1, O_RdId=3, O_RdData=0xDEADBEEF.
- Addr 9 holds 0x11; same cycle write 0x22 (req 0) and read addr 9 (req 1) -> read returns 0x11; a later read returns 0x22.
- RdPtr=2, I_RdReq=4'b0011 -> grant 0001 (wrap), RdPtr becomes 1.
- Read granted, I_Reset asserted the next edge -> O_RdValid stays 0, pointers return to 0, and all grants read 0 during reset.
- Continuous I_RdReq=4'b1010 for 6 cycles -> grants alternate 0010/1000, O_RdValid=1 every cycle from cycle 2, O_RdId alternating 1/3.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port-per-direction SRAM (one write port, one read port)
// between NUM_REQ requesters. Writes and reads are arbitrated independently,
// each by its own round-robin pointer. A grant completes its transfer in the
// same cycle: the granted requester's address/data are steered straight onto
// the RAM port. Read data comes back from the RAM one cycle later and is tagged
// with the requester index that issued it.
//
// Ports
//   I_Clk, I_Reset           clock, synchronous active-high reset
//   I_WrReq/I_WrAddr/I_WrData  per-requester write requests (slice i = req i)
//   O_WrGnt                  one-hot write grant (combinational)
//   I_RdReq/I_RdAddr         per-requester read requests
//   O_RdGnt                  one-hot read grant (combinational)
//   O_RdValid/O_RdId/O_RdData  read return: valid and owner registered, data
//                            passed through from I_RamRdData
//   O_RamWr*, O_RamRd*       RAM write and read ports
//   I_RamRdData              RAM read data, valid one cycle after O_RamRdEn
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 64,
  parameter int unsigned NUM_REQ    = 4,
  localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH),
  localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                             I_Clk,
  input  logic                             I_Reset,
  // write requesters
  input  logic [NUM_REQ-1:0]               I_WrReq,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    I_WrAddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    I_WrData,
  output logic [NUM_REQ-1:0]               O_WrGnt,
  // read requesters
  input  logic [NUM_REQ-1:0]               I_RdReq,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    I_RdAddr,
  output logic [NUM_REQ-1:0]               O_RdGnt,
  output logic                             O_RdValid,
  output logic [ID_WIDTH-1:0]              O_RdId,
  output logic [DATA_WIDTH-1:0]            O_RdData,
  // RAM side
  output logic                             O_RamWrEn,
  output logic [ADDR_WIDTH-1:0]            O_RamWrAddr,
  output logic [DATA_WIDTH-1:0]            O_RamWrData,
  output logic                             O_RamRdEn,
  output logic [ADDR_WIDTH-1:0]            O_RamRdAddr,
  input  logic [DATA_WIDTH-1:0]            I_RamRdData
);

  localparam logic [NUM_REQ-1:0]  OneHotZero = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_WIDTH-1:0] LastId     = ID_WIDTH'(NUM_REQ - 1);

  // ---------------------------------------------------------------------------
  // Round-robin pick: index of the first set request at or after ptr, scanning
  // upward and wrapping from NUM_REQ-1 to 0. Caller qualifies with |req.
  // ---------------------------------------------------------------------------
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0]  req,
                                                  input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH-1:0] idx;
    logic                found;
    int                  j;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      j = (int'(ptr) + k) % int'(NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = ID_WIDTH'(j);
      end
    end
    return idx;
  endfunction

  // Pointer after serving idx, wrapping at NUM_REQ (which need not be 2^n).
  function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] idx);
    return (idx == LastId) ? '0 : idx + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ID_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ID_WIDTH-1:0] rd_id_q, rd_id_d;

  // ---------------------------------------------------------------------------
  // Write arbitration and RAM write port
  // ---------------------------------------------------------------------------
  logic                wr_hit;
  logic [ID_WIDTH-1:0] wr_idx;

  always_comb begin
    // Reset masks every request so nothing reaches the RAM during reset.
    wr_hit      = ~I_Reset & (|I_WrReq);
    wr_idx      = rr_pick(I_WrReq, wr_ptr_q);
    O_WrGnt     = '0;
    O_RamWrEn   = 1'b0;
    O_RamWrAddr = '0;
    O_RamWrData = '0;
    wr_ptr_d    = wr_ptr_q;
    if (wr_hit) begin
      O_WrGnt     = OneHotZero << wr_idx;
      O_RamWrEn   = 1'b1;
      O_RamWrAddr = I_WrAddr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
      O_RamWrData = I_WrData[wr_idx*DATA_WIDTH +: DATA_WIDTH];
      wr_ptr_d    = next_ptr(wr_idx);
    end
  end

  // ---------------------------------------------------------------------------
  // Read arbitration and RAM read port
  // ---------------------------------------------------------------------------
  logic                rd_hit;
  logic [ID_WIDTH-1:0] rd_idx;

  always_comb begin
    rd_hit      = ~I_Reset & (|I_RdReq);
    rd_idx      = rr_pick(I_RdReq, rd_ptr_q);
    O_RdGnt     = '0;
    O_RamRdEn   = 1'b0;
    O_RamRdAddr = '0;
    rd_ptr_d    = rd_ptr_q;
    // Return tag follows the RAM's one-cycle read latency.
    rd_valid_d  = rd_hit;
    rd_id_d     = rd_hit ? rd_idx : '0;
    if (rd_hit) begin
      O_RdGnt     = OneHotZero << rd_idx;
      O_RamRdEn   = 1'b1;
      O_RamRdAddr = I_RdAddr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
      rd_ptr_d    = next_ptr(rd_idx);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_Clk) begin
    if (I_Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  assign O_RdValid = rd_valid_q;
  assign O_RdId    = rd_id_q;
  // No forwarding: a same-cycle write is invisible to the read, which returns
  // whatever the RAM held before the write edge.
  assign O_RdData  = I_RamRdData;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned IW = 2;

  logic              I_Clk;
  logic              I_Reset;
  logic [NR-1:0]     wr_req, rd_req;
  logic [AW-1:0]     wr_addr [NR];
  logic [DW-1:0]     wr_data [NR];
  logic [AW-1:0]     rd_addr [NR];
  logic [NR*AW-1:0]  I_WrAddr, I_RdAddr;
  logic [NR*DW-1:0]  I_WrData;
  logic [NR-1:0]     O_WrGnt, O_RdGnt;
  logic              O_RdValid;
  logic [IW-1:0]     O_RdId;
  logic [DW-1:0]     O_RdData;
  logic              O_RamWrEn, O_RamRdEn;
  logic [AW-1:0]     O_RamWrAddr, O_RamRdAddr;
  logic [DW-1:0]     O_RamWrData;
  logic [DW-1:0]     ram_rd_q;

  always_comb begin
    I_WrAddr = '0;
    I_WrData = '0;
    I_RdAddr = '0;
    for (int i = 0; i < int'(NR); i++) begin
      I_WrAddr[i*AW +: AW] = wr_addr[i];
      I_WrData[i*DW +: DW] = wr_data[i];
      I_RdAddr[i*AW +: AW] = rd_addr[i];
    end
  end

  sram_port_arbiter #(
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (DEPTH),
    .NUM_REQ    (NR)
  ) dut (
    .I_Clk       (I_Clk),
    .I_Reset     (I_Reset),
    .I_WrReq     (wr_req),
    .I_WrAddr    (I_WrAddr),
    .I_WrData    (I_WrData),
    .O_WrGnt     (O_WrGnt),
    .I_RdReq     (rd_req),
    .I_RdAddr    (I_RdAddr),
    .O_RdGnt     (O_RdGnt),
    .O_RdValid   (O_RdValid),
    .O_RdId      (O_RdId),
    .O_RdData    (O_RdData),
    .O_RamWrEn   (O_RamWrEn),
    .O_RamWrAddr (O_RamWrAddr),
    .O_RamWrData (O_RamWrData),
    .O_RamRdEn   (O_RamRdEn),
    .O_RamRdAddr (O_RamRdAddr),
    .I_RamRdData (ram_rd_q)
  );

  initial I_Clk = 1'b0;
  always #5 I_Clk = ~I_Clk;

  // External SRAM driven by the DUT's RAM ports (registered read).
  logic [DW-1:0] ram [DEPTH];
  always @(posedge I_Clk) begin
    if (O_RamWrEn) ram[O_RamWrAddr] <= O_RamWrData;
    if (O_RamRdEn) ram_rd_q <= ram[O_RamRdAddr];
  end

  // Bench's own view of memory contents, updated from expected grants.
  logic [DW-1:0] model_mem [DEPTH];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;
  always @(posedge I_Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard of expected read returns, stamped with the cycle they are due.
  typedef struct {
    int            due;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];

  always @(negedge I_Clk) begin
    if (started) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk("rd_valid_missing", 32'(O_RdValid), 32'd1);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("rd_valid", 32'(O_RdValid), 32'd1);
        chk("rd_id", 32'(O_RdId), 32'(sb[0].id));
        chk("rd_data", O_RdData, sb[0].data);
        void'(sb.pop_front());
      end else if (O_RdValid === 1'b1) begin
        chk("rd_valid_unexpected", 32'(O_RdValid), 32'd0);
      end
    end
  end

  function automatic int oh2idx(input logic [NR-1:0] oh);
    for (int i = 0; i < int'(NR); i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Drive one cycle of requests, check grants and RAM ports mid-cycle, then
  // record expected effects and advance to just after the next rising edge.
  task automatic apply(input logic rst, input logic [NR-1:0] wr, input logic [NR-1:0] rd,
                       input logic [NR-1:0] ew, input logic [NR-1:0] er);
    int wi, ri;
    I_Reset = rst;
    wr_req  = wr;
    rd_req  = rd;
    #2;
    wi = oh2idx(ew);
    ri = oh2idx(er);
    chk("wr_gnt", 32'(O_WrGnt), 32'(ew));
    chk("rd_gnt", 32'(O_RdGnt), 32'(er));
    chk("ram_wr_en", 32'(O_RamWrEn), 32'(|ew));
    chk("ram_rd_en", 32'(O_RamRdEn), 32'(|er));
    chk("ram_wr_addr", 32'(O_RamWrAddr), (|ew) ? 32'(wr_addr[wi]) : 32'd0);
    chk("ram_wr_data", O_RamWrData, (|ew) ? wr_data[wi] : 32'd0);
    chk("ram_rd_addr", 32'(O_RamRdAddr), (|er) ? 32'(rd_addr[ri]) : 32'd0);
    // Read sees pre-write contents, so queue it before applying the write.
    if (|er) sb.push_back('{due: cyc + 1, id: IW'(ri), data: model_mem[rd_addr[ri]]});
    if (|ew) model_mem[wr_addr[wi]] = wr_data[wi];
    @(posedge I_Clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [NR-1:0] wr;
    logic [NR-1:0] rd;
    logic [NR-1:0] ew;
    logic [NR-1:0] er;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{rst: 1'b1, wr: 4'b1111, rd: 4'b1111, ew: 4'b0000, er: 4'b0000};
    tbl[1] = '{rst: 1'b1, wr: 4'b1111, rd: 4'b1111, ew: 4'b0000, er: 4'b0000};
    tbl[2] = '{rst: 1'b0, wr: 4'b1111, rd: 4'b0000, ew: 4'b0001, er: 4'b0000};
    tbl[3] = '{rst: 1'b0, wr: 4'b1111, rd: 4'b0000, ew: 4'b0010, er: 4'b0000};
    tbl[4] = '{rst: 1'b0, wr: 4'b1111, rd: 4'b0000, ew: 4'b0100, er: 4'b0000};
    tbl[5] = '{rst: 1'b0, wr: 4'b1111, rd: 4'b0000, ew: 4'b1000, er: 4'b0000};

    for (int a = 0; a < int'(DEPTH); a++) begin
      ram[a]       = '0;
      model_mem[a] = '0;
    end
    ram_rd_q = '0;
    I_Reset  = 1'b1;
    wr_req   = '0;
    rd_req   = '0;
    for (int i = 0; i < int'(NR); i++) begin
      wr_addr[i] = AW'(10 + i);
      wr_data[i] = 32'hA000_0000 + 32'(i);
      rd_addr[i] = '0;
    end
    @(posedge I_Clk);
    #1;
    started = 1;

    // Reset then four-way write rotation.
    for (int v = 0; v < 6; v++) begin
      apply(tbl[v].rst, tbl[v].wr, tbl[v].rd, tbl[v].ew, tbl[v].er);
      if (v == 0) begin
        chk("reset_rd_valid", 32'(O_RdValid), 32'd0);
        chk("reset_rd_id", 32'(O_RdId), 32'd0);
      end
    end
    // RAM actually received each slice.
    for (int i = 0; i < int'(NR); i++)
      chk("ram_contents", ram[10 + i], 32'hA000_0000 + 32'(i));

    // Write DEADBEEF to 5 via req 2, then read it via req 3.
    wr_addr[2] = 6'd5;
    wr_data[2] = 32'hDEAD_BEEF;
    rd_addr[3] = 6'd5;
    apply(1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    apply(1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
    apply(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Same-cycle read/write to addr 9: read returns old value.
    wr_addr[1] = 6'd9;
    wr_data[1] = 32'h11;
    apply(1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000);   // WrPtr 3 -> grant 1
    wr_addr[0] = 6'd9;
    wr_data[0] = 32'h22;
    rd_addr[1] = 6'd9;
    apply(1'b0, 4'b0001, 4'b0010, 4'b0001, 4'b0010);   // expects 0x11
    apply(1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0010);   // expects 0x22, RdPtr -> 2

    // RdPtr=2, requests 0011: wrap to 0, then pointer at 1 favours req 1.
    rd_addr[0] = 6'd10;
    apply(1'b0, 4'b0000, 4'b0011, 4'b0000, 4'b0001);
    apply(1'b0, 4'b0000, 4'b0011, 4'b0000, 4'b0010);   // RdPtr -> 2

    // Read granted, then reset: no valid after the reset edge.
    apply(1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
    apply(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    chk("post_reset_rd_valid", 32'(O_RdValid), 32'd0);
    chk("post_reset_rd_id", 32'(O_RdId), 32'd0);
    apply(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    apply(1'b0, 4'b1111, 4'b1111, 4'b0001, 4'b0001);   // pointers back at 0

    // Continuous 1010 reads: alternate 1/3, one return per cycle.
    rd_addr[1] = 6'd9;
    rd_addr[3] = 6'd5;
    for (int c = 0; c < 6; c++)
      apply(1'b0, 4'b0000, 4'b1010, 4'b0000, (c % 2 == 0) ? 4'b0010 : 4'b1000);
    apply(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    apply(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
